// File: rtl/register_file_sb_if.sv
// Register file bus: read ports, writeback, issue scoreboard and sweep control.
// Handshakes are level-based: every request is sampled on the rising clock edge and there is no ready/backpressure.
interface register_file_sb_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   read_reg1;
   logic [AW-1:0]   read_reg2;
   logic [XLEN-1:0] reg1_value;
   logic [XLEN-1:0] reg2_value;
   logic            reg1_busy;
   logic            reg2_busy;
   logic            regwrite;
   logic [AW-1:0]   write_reg;
   logic [XLEN-1:0] write_data;
   logic            issue_valid;
   logic [AW-1:0]   issue_reg;
   logic            clear_req;
   logic            clear_busy;
   logic            clear_done;
   logic [1:0]      fsm_state;

   modport master (
      output read_reg1, read_reg2, regwrite, write_reg, write_data,
             issue_valid, issue_reg, clear_req,
      input  reg1_value, reg2_value, reg1_busy, reg2_busy,
             clear_busy, clear_done, fsm_state
   );

   modport slave (
      input  read_reg1, read_reg2, regwrite, write_reg, write_data,
             issue_valid, issue_reg, clear_req,
      output reg1_value, reg2_value, reg1_busy, reg2_busy,
             clear_busy, clear_done, fsm_state
   );
endinterface

// File: rtl/register_file_sb.sv
// Register file with per-register busy scoreboard and a sequential clear sweep.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module register_file_sb #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic                clock,
   input  logic                reset,
   register_file_sb_if.slave   rf
);

   localparam int NREGS = 2 ** AW;
   localparam logic [AW-1:0] FIRST_REG = AW'(1);
   localparam logic [AW-1:0] LAST_REG  = AW'(NREGS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [XLEN-1:0] regs_q [NREGS];
   logic [NREGS-1:0] busy_q;

   logic            sweep_we;
   logic            clear_busy;
   logic            clear_done;
   logic            wr_en;
   logic            iss_en;
   logic [XLEN-1:0] rd1_data, rd2_data;
   logic            rd1_busy, rd2_busy;

   assign wr_en  = rf.regwrite && (rf.write_reg != '0);
   assign iss_en = rf.issue_valid && (rf.issue_reg != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= FIRST_REG;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      sweep_we   = 1'b0;
      clear_busy = 1'b0;
      clear_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (rf.clear_req) state_d = SWEEP;
         end
         SWEEP: begin
            clear_busy = 1'b1;
            sweep_we   = 1'b1;
            if (ptr_q == LAST_REG) begin
               state_d = DONE;
               ptr_d   = FIRST_REG;
            end else begin
               ptr_d = ptr_q + FIRST_REG;
            end
         end
         DONE: begin
            clear_busy = 1'b1;
            clear_done = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
            ptr_d   = FIRST_REG;
         end
      endcase
   end

   // Issue is applied after the writeback so a same-edge issue leaves the register pending.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else if (sweep_we) begin
         regs_q[ptr_q] <= '0;
         busy_q[ptr_q] <= 1'b0;
      end else if (!clear_busy) begin
         if (wr_en) begin
            regs_q[rf.write_reg] <= rf.write_data;
            busy_q[rf.write_reg] <= 1'b0;
         end
         if (iss_en) busy_q[rf.issue_reg] <= 1'b1;
      end
   end

   always_comb begin
      rd1_data = regs_q[rf.read_reg1];
      rd1_busy = busy_q[rf.read_reg1];
      rd2_data = regs_q[rf.read_reg2];
      rd2_busy = busy_q[rf.read_reg2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && !clear_busy && (rf.read_reg1 == rf.write_reg)) begin
         rd1_data = rf.write_data;
         rd1_busy = 1'b0;
      end
      if (wr_en && !clear_busy && (rf.read_reg2 == rf.write_reg)) begin
         rd2_data = rf.write_data;
         rd2_busy = 1'b0;
      end
`endif
      // x0 is hardwired; reset also masks the forwarding path.
      if (reset || (rf.read_reg1 == '0)) begin
         rd1_data = '0;
         rd1_busy = 1'b0;
      end
      if (reset || (rf.read_reg2 == '0)) begin
         rd2_data = '0;
         rd2_busy = 1'b0;
      end
   end

   assign rf.reg1_value = rd1_data;
   assign rf.reg2_value = rd2_data;
   assign rf.reg1_busy  = rd1_busy;
   assign rf.reg2_busy  = rd2_busy;
   assign rf.clear_busy = clear_busy;
   assign rf.clear_done = clear_done;
   assign rf.fsm_state  = state_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios plus randomized traffic against an array model.
module tb_register_file_sb;

   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int NREGS = 32;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   register_file_sb_if #(.XLEN(XLEN), .AW(AW)) rf ();

   register_file_sb #(.XLEN(XLEN), .AW(AW)) dut (
      .clock (clock),
      .reset (reset),
      .rf    (rf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: architectural contents, pending bits, and position within a sweep (0 = idle).
   logic [XLEN-1:0] m_regs [NREGS];
   logic            m_busy [NREGS];
   int              sweep_pos;

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      sweep_pos = 0;
   endtask

   task automatic drive_idle();
      rf.regwrite    = 1'b0;
      rf.write_reg   = '0;
      rf.write_data  = '0;
      rf.issue_valid = 1'b0;
      rf.issue_reg   = '0;
      rf.clear_req   = 1'b0;
   endtask

   function automatic bit bypass_hit(input logic [AW-1:0] a);
      bit hit;
      hit = (sweep_pos == 0) && !reset && rf.regwrite && (rf.write_reg != 0) && (rf.write_reg == a);
`ifndef REGFILE_BYPASS_EN
      hit = 1'b0;
`endif
      return hit;
   endfunction

   function automatic logic [XLEN-1:0] exp_val(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (bypass_hit(a)) return rf.write_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (a == 0 || bypass_hit(a)) return 1'b0;
      return m_busy[a];
   endfunction

   // Advance the model by one rising edge using the inputs currently driven, then step the DUT.
   task automatic tick();
      if (!reset) begin
         if (sweep_pos != 0) begin
            if (sweep_pos <= NREGS - 1) begin
               m_regs[sweep_pos] = '0;
               m_busy[sweep_pos] = 1'b0;
            end
            sweep_pos = (sweep_pos == NREGS) ? 0 : sweep_pos + 1;
         end else begin
            if (rf.regwrite && rf.write_reg != 0) begin
               m_regs[rf.write_reg] = rf.write_data;
               m_busy[rf.write_reg] = 1'b0;
            end
            if (rf.issue_valid && rf.issue_reg != 0) m_busy[rf.issue_reg] = 1'b1;
            if (rf.clear_req) sweep_pos = 1;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      drive_idle();
      rf.read_reg1 = 5'd5;
      rf.read_reg2 = 5'd31;
      reset = 1'b1;
      model_reset();
      @(posedge clock);
      #1;
      checks++; if (rf.reg1_value !== '0) begin errors++; $display("FAIL reset_reg1_value actual=%h expected=0", rf.reg1_value); end
      checks++; if (rf.reg2_value !== '0) begin errors++; $display("FAIL reset_reg2_value actual=%h expected=0", rf.reg2_value); end
      checks++; if (rf.reg1_busy !== 1'b0) begin errors++; $display("FAIL reset_reg1_busy actual=%b expected=0", rf.reg1_busy); end
      checks++; if (rf.reg2_busy !== 1'b0) begin errors++; $display("FAIL reset_reg2_busy actual=%b expected=0", rf.reg2_busy); end
      checks++; if (rf.clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy actual=%b expected=0", rf.clear_busy); end
      checks++; if (rf.clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done actual=%b expected=0", rf.clear_done); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_write_readback();
      rf.regwrite = 1'b1; rf.write_reg = 5'd5; rf.write_data = 32'hDEADBEEF;
      tick();
      drive_idle();
      rf.read_reg1 = 5'd5;
      #1;
      checks++; if (rf.reg1_value !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_x5 actual=%h expected=deadbeef", rf.reg1_value); end
      rf.regwrite = 1'b1; rf.write_reg = 5'd0; rf.write_data = 32'h1234;
      tick();
      drive_idle();
      rf.read_reg2 = 5'd0;
      #1;
      checks++; if (rf.reg2_value !== '0) begin errors++; $display("FAIL wr_x0_ignored actual=%h expected=0", rf.reg2_value); end
      checks++; if (rf.reg2_busy !== 1'b0) begin errors++; $display("FAIL x0_busy actual=%b expected=0", rf.reg2_busy); end
   endtask

   task automatic test_scoreboard();
      rf.issue_valid = 1'b1; rf.issue_reg = 5'd7;
      tick();
      drive_idle();
      rf.read_reg1 = 5'd7;
      #1;
      checks++; if (rf.reg1_busy !== 1'b1) begin errors++; $display("FAIL issue_x7_busy actual=%b expected=1", rf.reg1_busy); end
      rf.regwrite = 1'b1; rf.write_reg = 5'd7; rf.write_data = 32'h55;
      tick();
      drive_idle();
      #1;
      checks++; if (rf.reg1_busy !== 1'b0) begin errors++; $display("FAIL wb_x7_busy actual=%b expected=0", rf.reg1_busy); end
      checks++; if (rf.reg1_value !== 32'h55) begin errors++; $display("FAIL wb_x7_value actual=%h expected=55", rf.reg1_value); end
      rf.regwrite = 1'b1; rf.write_reg = 5'd9; rf.write_data = 32'h99;
      rf.issue_valid = 1'b1; rf.issue_reg = 5'd9;
      tick();
      drive_idle();
      rf.read_reg2 = 5'd9;
      #1;
      checks++; if (rf.reg2_busy !== 1'b1) begin errors++; $display("FAIL same_edge_x9_busy actual=%b expected=1", rf.reg2_busy); end
      checks++; if (rf.reg2_value !== 32'h99) begin errors++; $display("FAIL same_edge_x9_value actual=%h expected=99", rf.reg2_value); end
      rf.issue_valid = 1'b1; rf.issue_reg = 5'd0;
      tick();
      drive_idle();
      rf.read_reg1 = 5'd0;
      #1;
      checks++; if (rf.reg1_busy !== 1'b0) begin errors++; $display("FAIL issue_x0_busy actual=%b expected=0", rf.reg1_busy); end
   endtask

   task automatic test_bypass();
      logic [XLEN-1:0] want_v;
      logic            want_b;
      rf.regwrite = 1'b1; rf.write_reg = 5'd3; rf.write_data = 32'h11111111;
      tick();
      drive_idle();
      rf.issue_valid = 1'b1; rf.issue_reg = 5'd3;
      tick();
      drive_idle();
      rf.regwrite = 1'b1; rf.write_reg = 5'd3; rf.write_data = 32'hA5A5A5A5;
      rf.read_reg1 = 5'd3;
      #1;
`ifdef REGFILE_BYPASS_EN
      want_v = 32'hA5A5A5A5; want_b = 1'b0;
`else
      want_v = 32'h11111111; want_b = 1'b1;
`endif
      checks++; if (rf.reg1_value !== want_v) begin errors++; $display("FAIL bypass_value actual=%h expected=%h", rf.reg1_value, want_v); end
      checks++; if (rf.reg1_busy !== want_b) begin errors++; $display("FAIL bypass_busy actual=%b expected=%b", rf.reg1_busy, want_b); end
      tick();
      drive_idle();
      #1;
      checks++; if (rf.reg1_value !== 32'hA5A5A5A5) begin errors++; $display("FAIL post_bypass_value actual=%h expected=a5a5a5a5", rf.reg1_value); end
      checks++; if (rf.reg1_busy !== 1'b0) begin errors++; $display("FAIL post_bypass_busy actual=%b expected=0", rf.reg1_busy); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 200; n++) begin
         rf.regwrite    = 1'($urandom_range(0, 1));
         rf.write_reg   = AW'($urandom_range(0, NREGS - 1));
         rf.write_data  = $urandom();
         rf.issue_valid = 1'($urandom_range(0, 1));
         rf.issue_reg   = AW'($urandom_range(0, NREGS - 1));
         rf.clear_req   = 1'b0;
         rf.read_reg1   = ($urandom_range(0, 3) == 0) ? rf.write_reg : AW'($urandom_range(0, NREGS - 1));
         rf.read_reg2   = ($urandom_range(0, 3) == 0) ? rf.issue_reg : AW'($urandom_range(0, NREGS - 1));
         #1;
         checks++; if (rf.reg1_value !== exp_val(rf.read_reg1)) begin errors++; $display("FAIL rnd_reg1_value n=%0d a=%0d actual=%h expected=%h", n, rf.read_reg1, rf.reg1_value, exp_val(rf.read_reg1)); end
         checks++; if (rf.reg2_value !== exp_val(rf.read_reg2)) begin errors++; $display("FAIL rnd_reg2_value n=%0d a=%0d actual=%h expected=%h", n, rf.read_reg2, rf.reg2_value, exp_val(rf.read_reg2)); end
         checks++; if (rf.reg1_busy !== exp_busy(rf.read_reg1)) begin errors++; $display("FAIL rnd_reg1_busy n=%0d a=%0d actual=%b expected=%b", n, rf.read_reg1, rf.reg1_busy, exp_busy(rf.read_reg1)); end
         checks++; if (rf.reg2_busy !== exp_busy(rf.read_reg2)) begin errors++; $display("FAIL rnd_reg2_busy n=%0d a=%0d actual=%b expected=%b", n, rf.read_reg2, rf.reg2_busy, exp_busy(rf.read_reg2)); end
         checks++; if (rf.clear_busy !== 1'b0) begin errors++; $display("FAIL rnd_clear_busy n=%0d actual=%b expected=0", n, rf.clear_busy); end
         tick();
      end
      drive_idle();
   endtask

   task automatic test_sweep();
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at  = -1;
      drive_idle();
      rf.regwrite = 1'b1; rf.write_reg = 5'd1; rf.write_data = 32'h1;
      tick();
      rf.write_reg = 5'd31; rf.write_data = 32'hFFFFFFFF;
      tick();
      drive_idle();
      rf.issue_valid = 1'b1; rf.issue_reg = 5'd10;
      tick();
      drive_idle();
      rf.clear_req = 1'b1;
      tick();
      for (int c = 0; c < 36; c++) begin
         if (sweep_pos != 0) begin
            rf.regwrite    = 1'b1;
            rf.write_reg   = AW'($urandom_range(1, NREGS - 1));
            rf.write_data  = $urandom();
            rf.issue_valid = 1'b1;
            rf.issue_reg   = AW'($urandom_range(1, NREGS - 1));
            rf.clear_req   = 1'b1;
         end else begin
            drive_idle();
         end
         rf.read_reg1 = (c % 2 == 0) ? 5'd31 : rf.write_reg;
         rf.read_reg2 = AW'($urandom_range(0, NREGS - 1));
         #1;
         if (rf.clear_busy === 1'b1) busy_cnt++;
         if (rf.clear_done === 1'b1) begin done_cnt++; done_at = busy_cnt; end
         checks++; if (rf.clear_busy !== (sweep_pos != 0)) begin errors++; $display("FAIL sweep_clear_busy c=%0d actual=%b expected=%b", c, rf.clear_busy, (sweep_pos != 0)); end
         checks++; if (rf.clear_done !== (sweep_pos == NREGS)) begin errors++; $display("FAIL sweep_clear_done c=%0d actual=%b expected=%b", c, rf.clear_done, (sweep_pos == NREGS)); end
         checks++; if (rf.reg1_value !== exp_val(rf.read_reg1)) begin errors++; $display("FAIL sweep_reg1_value c=%0d a=%0d actual=%h expected=%h", c, rf.read_reg1, rf.reg1_value, exp_val(rf.read_reg1)); end
         checks++; if (rf.reg2_busy !== exp_busy(rf.read_reg2)) begin errors++; $display("FAIL sweep_reg2_busy c=%0d a=%0d actual=%b expected=%b", c, rf.read_reg2, rf.reg2_busy, exp_busy(rf.read_reg2)); end
         tick();
      end
      drive_idle();
      checks++; if (busy_cnt != 32) begin errors++; $display("FAIL sweep_length actual=%0d expected=32", busy_cnt); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL sweep_done_pulses actual=%0d expected=1", done_cnt); end
      checks++; if (done_at != 32) begin errors++; $display("FAIL sweep_done_position actual=%0d expected=32", done_at); end
      rf.read_reg1 = 5'd31;
      rf.read_reg2 = 5'd1;
      #1;
      checks++; if (rf.reg1_value !== '0) begin errors++; $display("FAIL sweep_x31_cleared actual=%h expected=0", rf.reg1_value); end
      checks++; if (rf.reg2_value !== '0) begin errors++; $display("FAIL sweep_x1_cleared actual=%h expected=0", rf.reg2_value); end
      rf.read_reg2 = 5'd10;
      #1;
      checks++; if (rf.reg2_busy !== 1'b0) begin errors++; $display("FAIL sweep_x10_busy actual=%b expected=0", rf.reg2_busy); end
   endtask

   task automatic test_reset_mid_sweep();
      int flag_cycles = 0;
      drive_idle();
      rf.regwrite = 1'b1; rf.write_reg = 5'd31; rf.write_data = 32'hCAFEF00D;
      rf.issue_valid = 1'b1; rf.issue_reg = 5'd12;
      tick();
      drive_idle();
      rf.clear_req = 1'b1;
      tick();
      drive_idle();
      for (int c = 1; c < 10; c++) tick();
      rf.regwrite = 1'b1; rf.write_reg = 5'd31; rf.write_data = 32'h77;
      rf.read_reg1 = 5'd31;
      rf.read_reg2 = 5'd12;
      #1;
      checks++; if (rf.reg1_value !== 32'hCAFEF00D) begin errors++; $display("FAIL midsweep_unswept_x31 actual=%h expected=cafef00d", rf.reg1_value); end
      checks++; if (rf.reg2_busy !== 1'b1) begin errors++; $display("FAIL midsweep_x12_busy actual=%b expected=1", rf.reg2_busy); end
      checks++; if (rf.clear_busy !== 1'b1) begin errors++; $display("FAIL midsweep_clear_busy actual=%b expected=1", rf.clear_busy); end
      reset = 1'b1;
      model_reset();
      #1;
      checks++; if (rf.reg1_value !== '0) begin errors++; $display("FAIL rst_mid_reg1_value actual=%h expected=0", rf.reg1_value); end
      checks++; if (rf.reg2_value !== '0) begin errors++; $display("FAIL rst_mid_reg2_value actual=%h expected=0", rf.reg2_value); end
      checks++; if (rf.reg1_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_reg1_busy actual=%b expected=0", rf.reg1_busy); end
      checks++; if (rf.reg2_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_reg2_busy actual=%b expected=0", rf.reg2_busy); end
      checks++; if (rf.clear_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_clear_busy actual=%b expected=0", rf.clear_busy); end
      checks++; if (rf.clear_done !== 1'b0) begin errors++; $display("FAIL rst_mid_clear_done actual=%b expected=0", rf.clear_done); end
      tick();
      tick();
      drive_idle();
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (rf.clear_busy !== 1'b0 || rf.clear_done !== 1'b0) flag_cycles++;
         tick();
      end
      checks++; if (flag_cycles != 0) begin errors++; $display("FAIL rst_mid_no_resume actual=%0d expected=0", flag_cycles); end
      rf.read_reg1 = 5'd31;
      rf.read_reg2 = 5'd12;
      #1;
      checks++; if (rf.reg1_value !== '0) begin errors++; $display("FAIL rst_mid_x31_after actual=%h expected=0", rf.reg1_value); end
      checks++; if (rf.reg2_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_x12_after actual=%b expected=0", rf.reg2_busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      rf.read_reg1 = '0;
      rf.read_reg2 = '0;
      drive_idle();
      model_reset();
      test_reset();
      test_write_readback();
      test_scoreboard();
      test_bypass();
      test_random();
      test_sweep();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
